// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared widths, mode encoding and rounding/saturation helpers for FFT stages
package fft_pkg;

  localparam int DEF_DATA_W  = 16;
  localparam int DEF_COEFF_W = 16;
  localparam int DEF_FRAC_W  = 15;
  localparam int DEF_OUT_W   = 16;
  localparam int DEF_SCALE   = 1;

  typedef enum logic {
    MODE_DIT = 1'b0,
    MODE_DIF = 1'b1
  } mode_e;

  // Half an LSB of a Q1.frac_w product, added before the right shift for round-half-up.
  function automatic logic signed [63:0] round_half(input int frac_w);
    return 64'sd1 <<< (frac_w - 1);
  endfunction

  // Clamp a wide signed value into the range of an out_w-bit signed number.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] x, input int out_w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (x > hi) begin
      return hi;
    end else if (x < lo) begin
      return lo;
    end
    return x;
  endfunction

endpackage

// File: rtl/cmult_round.sv
// rtl/cmult_round.sv - registered complex multiply x*w with round-half-up and Q-format shift
module cmult_round
  import fft_pkg::*;
#(
  parameter int XW      = DEF_DATA_W + 1,
  parameter int COEFF_W = DEF_COEFF_W,
  parameter int FRAC_W  = DEF_FRAC_W,
  parameter int MW      = XW + COEFF_W + 1,
  parameter int RW      = MW - FRAC_W
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_en,
  input  logic signed [XW-1:0]      i_x_re,
  input  logic signed [XW-1:0]      i_x_im,
  input  logic signed [COEFF_W-1:0] i_w_re,
  input  logic signed [COEFF_W-1:0] i_w_im,
  output logic signed [RW-1:0]      o_p_re,
  output logic signed [RW-1:0]      o_p_im
);

  localparam logic signed [MW-1:0] ROUND = MW'(round_half(FRAC_W));

  logic signed [MW-1:0] w_xr;
  logic signed [MW-1:0] w_xi;
  logic signed [MW-1:0] w_wr;
  logic signed [MW-1:0] w_wi;
  logic signed [MW-1:0] w_sum_re;
  logic signed [MW-1:0] w_sum_im;
  logic signed [RW-1:0] r_p_re;
  logic signed [RW-1:0] r_p_im;

  // Operands widened to the full product width so each product and the sum are exact.
  assign w_xr = MW'(i_x_re);
  assign w_xi = MW'(i_x_im);
  assign w_wr = MW'(i_w_re);
  assign w_wi = MW'(i_w_im);

  assign w_sum_re = w_xr * w_wr - w_xi * w_wi + ROUND;
  assign w_sum_im = w_xr * w_wi + w_xi * w_wr + ROUND;

  // Register the rounded product; the arithmetic shift floors, so with ROUND added it rounds half up.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_p_re <= '0;
      r_p_im <= '0;
    end else if (i_en) begin
      r_p_re <= RW'(w_sum_re >>> FRAC_W);
      r_p_im <= RW'(w_sum_im >>> FRAC_W);
    end
  end

  assign o_p_re = r_p_re;
  assign o_p_im = r_p_im;

endmodule

// File: rtl/butterfly_pipe.sv
// rtl/butterfly_pipe.sv - 3-stage radix-2 DIT/DIF butterfly with valid/ready, scaling and saturation
module butterfly_pipe
  import fft_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int COEFF_W = DEF_COEFF_W,
  parameter int FRAC_W  = DEF_FRAC_W,
  parameter int OUT_W   = DEF_OUT_W,
  parameter int SCALE   = DEF_SCALE
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_in_valid,
  output logic                      o_in_ready,
  input  logic                      i_mode_dif,
  input  logic signed [DATA_W-1:0]  i_a_re,
  input  logic signed [DATA_W-1:0]  i_a_im,
  input  logic signed [DATA_W-1:0]  i_b_re,
  input  logic signed [DATA_W-1:0]  i_b_im,
  input  logic signed [COEFF_W-1:0] i_w_re,
  input  logic signed [COEFF_W-1:0] i_w_im,
  output logic                      o_out_valid,
  input  logic                      i_out_ready,
  output logic signed [OUT_W-1:0]   o_y0_re,
  output logic signed [OUT_W-1:0]   o_y0_im,
  output logic signed [OUT_W-1:0]   o_y1_re,
  output logic signed [OUT_W-1:0]   o_y1_im,
  output logic                      o_sat,
  output logic                      o_ovf_sticky,
  input  logic                      i_ovf_clr
);

  localparam int PW = DATA_W + 1;
  localparam int RW = DATA_W + COEFF_W + 2 - FRAC_W;
  localparam int SW = ((RW > PW) ? RW : PW) + 1;

  logic                      w_en;
  logic                      r1_valid;
  logic                      r2_valid;
  logic                      r_out_valid;
  mode_e                     r1_mode;
  mode_e                     r2_mode;
  logic signed [PW-1:0]      w_a_re, w_a_im, w_b_re, w_b_im;
  logic signed [PW-1:0]      r1_p_re, r1_p_im, r1_q_re, r1_q_im;
  logic signed [COEFF_W-1:0] r1_w_re, r1_w_im;
  logic signed [PW-1:0]      r2_p_re, r2_p_im;
  logic signed [RW-1:0]      w_m_re, w_m_im;
  logic signed [SW-1:0]      w_res [4];
  logic signed [SW-1:0]      w_sc  [4];
  logic signed [63:0]        w_ext [4];
  logic signed [63:0]        w_cl  [4];
  logic                      w_sat_any;
  logic signed [OUT_W-1:0]   r_y [4];
  logic                      r_sat;
  logic                      r_sticky;

  // One enable for the whole pipe: everything advances unless a result is waiting on downstream.
  assign w_en       = !r_out_valid || i_out_ready;
  assign o_in_ready = w_en;

  assign w_a_re = PW'(i_a_re);
  assign w_a_im = PW'(i_a_im);
  assign w_b_re = PW'(i_b_re);
  assign w_b_im = PW'(i_b_im);

  // S1: capture the beat; DIF forms sum/difference here so S2 always multiplies r1_q by W.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r1_valid <= 1'b0;
      r1_mode  <= MODE_DIT;
      r1_p_re  <= '0;
      r1_p_im  <= '0;
      r1_q_re  <= '0;
      r1_q_im  <= '0;
      r1_w_re  <= '0;
      r1_w_im  <= '0;
    end else if (w_en) begin
      r1_valid <= i_in_valid;
      r1_mode  <= mode_e'(i_mode_dif);
      r1_w_re  <= i_w_re;
      r1_w_im  <= i_w_im;
      if (i_mode_dif) begin
        r1_p_re <= w_a_re + w_b_re;
        r1_p_im <= w_a_im + w_b_im;
        r1_q_re <= w_a_re - w_b_re;
        r1_q_im <= w_a_im - w_b_im;
      end else begin
        r1_p_re <= w_a_re;
        r1_p_im <= w_a_im;
        r1_q_re <= w_b_re;
        r1_q_im <= w_b_im;
      end
    end
  end

  cmult_round #(
    .XW      (PW),
    .COEFF_W (COEFF_W),
    .FRAC_W  (FRAC_W)
  ) u_cmult (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (w_en),
    .i_x_re  (r1_q_re),
    .i_x_im  (r1_q_im),
    .i_w_re  (r1_w_re),
    .i_w_im  (r1_w_im),
    .o_p_re  (w_m_re),
    .o_p_im  (w_m_im)
  );

  // S2: carry the pass-through operand and mode alongside the multiplier stage.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r2_valid <= 1'b0;
      r2_mode  <= MODE_DIT;
      r2_p_re  <= '0;
      r2_p_im  <= '0;
    end else if (w_en) begin
      r2_valid <= r1_valid;
      r2_mode  <= r1_mode;
      r2_p_re  <= r1_p_re;
      r2_p_im  <= r1_p_im;
    end
  end

  // S3 datapath: combine, optionally halve with round-half-up, then clamp to the output range.
  always_comb begin
    w_sat_any = 1'b0;
    if (r2_mode == MODE_DIF) begin
      w_res[0] = SW'(r2_p_re);
      w_res[1] = SW'(r2_p_im);
      w_res[2] = SW'(w_m_re);
      w_res[3] = SW'(w_m_im);
    end else begin
      w_res[0] = SW'(r2_p_re) + SW'(w_m_re);
      w_res[1] = SW'(r2_p_im) + SW'(w_m_im);
      w_res[2] = SW'(r2_p_re) - SW'(w_m_re);
      w_res[3] = SW'(r2_p_im) - SW'(w_m_im);
    end
    for (int k = 0; k < 4; k++) begin
      w_sc[k]   = (SCALE != 0) ? ((w_res[k] + SW'(1)) >>> 1) : w_res[k];
      w_ext[k]  = 64'(w_sc[k]);
      w_cl[k]   = saturate(w_ext[k], OUT_W);
      w_sat_any = w_sat_any | (w_cl[k] != w_ext[k]);
    end
  end

  // S3 registers: the output beat and its saturation flag, held while downstream stalls.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_out_valid <= 1'b0;
      r_sat       <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        r_y[k] <= '0;
      end
    end else if (w_en) begin
      r_out_valid <= r2_valid;
      r_sat       <= w_sat_any;
      for (int k = 0; k < 4; k++) begin
        r_y[k] <= OUT_W'(w_cl[k]);
      end
    end
  end

  // Sticky overflow: set only when a saturated beat is actually handed off; clear has priority.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sticky <= 1'b0;
    end else if (i_ovf_clr) begin
      r_sticky <= 1'b0;
    end else if (r_out_valid && i_out_ready && r_sat) begin
      r_sticky <= 1'b1;
    end
  end

  assign o_out_valid  = r_out_valid;
  assign o_y0_re      = r_y[0];
  assign o_y0_im      = r_y[1];
  assign o_y1_re      = r_y[2];
  assign o_y1_im      = r_y[3];
  assign o_sat        = r_sat;
  assign o_ovf_sticky = r_sticky;

endmodule
